// File: rtl/data_sram_resp.sv
`default_nettype none
// ============================================================================
// data_sram_resp : data SRAM plus confreg page responding to the CPU data port
// Rev 1.0 : initial release
// ============================================================================
module data_sram_resp #(
  parameter int          RAM_AW  = 12,
  parameter logic [15:0] CONF_HI = 16'hbfaf,
  parameter bit          SIMU    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_memce,
  input  logic        i_memwrite,
  input  logic [3:0]  i_memsel,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic [15:0] o_led,
  output logic [31:0] o_num
);

  localparam int          c_RAM_DEPTH = 1 << RAM_AW;
  localparam logic [15:0] c_OFF_LED   = 16'hf000;
  localparam logic [15:0] c_OFF_NUM   = 16'hf010;
  localparam logic [15:0] c_OFF_TIMER = 16'he000;
  localparam logic [15:0] c_OFF_SIMU  = 16'hfff4;
  localparam logic [31:0] c_SIMU_VAL  = SIMU ? 32'hffff_ffff : 32'h0000_0000;

  logic [31:0] r_ram [c_RAM_DEPTH];
  logic [31:0] r_rdata;
  logic        r_err;
  logic [15:0] r_led;
  logic [31:0] r_num;
  logic [31:0] r_timer;

  logic              w_conf;
  logic              w_rd;
  logic              w_wr;
  logic              w_ram_we;
  logic              w_sel_led;
  logic              w_sel_num;
  logic              w_sel_tmr;
  logic              w_sel_simu;
  logic              w_unmapped;
  logic [RAM_AW-1:0] w_idx;
  logic [31:0]       w_wmask;
  logic [31:0]       w_timer_inc;
  logic [31:0]       w_rd_val;
  logic              w_unused;

  // Request decode
  assign w_conf     = (i_addr[31:16] == CONF_HI);
  assign w_rd       = i_memce & ~i_memwrite;
  assign w_wr       = i_memce &  i_memwrite;
  assign w_ram_we   = w_wr & ~w_conf;
  assign w_idx      = i_addr[RAM_AW+1:2];
  assign w_sel_led  = w_conf & (i_addr[15:0] == c_OFF_LED);
  assign w_sel_num  = w_conf & (i_addr[15:0] == c_OFF_NUM);
  assign w_sel_tmr  = w_conf & (i_addr[15:0] == c_OFF_TIMER);
  assign w_sel_simu = w_conf & (i_addr[15:0] == c_OFF_SIMU);
  assign w_unmapped = w_conf & ~(w_sel_led | w_sel_num | w_sel_tmr | w_sel_simu);
  assign w_unused   = ^i_addr[1:0];

  assign w_wmask     = {{8{i_memsel[3]}}, {8{i_memsel[2]}},
                        {8{i_memsel[1]}}, {8{i_memsel[0]}}};
  assign w_timer_inc = r_timer + 32'd1;

  // RAM is never reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (w_ram_we && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (i_memsel[b]) begin
          r_ram[w_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    w_rd_val = 32'h0000_0000;
    if (!w_conf) begin
      w_rd_val = r_ram[w_idx];
    end else if (w_sel_led) begin
      w_rd_val = {16'h0000, r_led};
    end else if (w_sel_num) begin
      w_rd_val = r_num;
    end else if (w_sel_tmr) begin
      w_rd_val = r_timer;
    end else if (w_sel_simu) begin
      w_rd_val = c_SIMU_VAL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= 32'h0000_0000;
      r_err   <= 1'b0;
    end else begin
      if (w_rd) begin
        r_rdata <= w_rd_val;
      end
      r_err <= i_memce & w_unmapped;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led <= 16'h0000;
      r_num <= 32'h0000_0000;
    end else begin
      if (w_wr && w_sel_led) begin
        r_led <= (r_led & ~w_wmask[15:0]) | (i_wdata[15:0] & w_wmask[15:0]);
      end
      if (w_wr && w_sel_num) begin
        r_num <= (r_num & ~w_wmask) | (i_wdata & w_wmask);
      end
    end
  end

  // Unwritten timer lanes keep counting so a partial write does not stall them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= 32'h0000_0000;
    end else if (w_wr && w_sel_tmr) begin
      r_timer <= (w_timer_inc & ~w_wmask) | (i_wdata & w_wmask);
    end else begin
      r_timer <= w_timer_inc;
    end
  end

  assign o_rdata = r_rdata;
  assign o_err   = r_err;
  assign o_led   = r_led;
  assign o_num   = r_num;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_resp.sv
`default_nettype none
// tb_data_sram_resp : directed and randomized checks of data_sram_resp
// against a transaction-level model of the memory map.
module tb_data_sram_resp;

  localparam int          RAM_AW  = 12;
  localparam logic [15:0] CONF_HI = 16'hbfaf;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        memce    = 1'b0;
  logic        memwrite = 1'b0;
  logic [3:0]  memsel   = 4'h0;
  logic [31:0] addr     = 32'h0;
  logic [31:0] wdata    = 32'h0;
  logic [31:0] rdata;
  logic        err;
  logic [15:0] led;
  logic [31:0] num;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_ram [int];
  logic [15:0] m_led   = 16'h0;
  logic [31:0] m_num   = 32'h0;
  logic [31:0] m_timer = 32'h0;
  logic [31:0] m_rdata = 32'h0;
  logic        m_err   = 1'b0;

  data_sram_resp #(.RAM_AW(RAM_AW), .CONF_HI(CONF_HI), .SIMU(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_memce   (memce),
    .i_memwrite(memwrite),
    .i_memsel  (memsel),
    .i_addr    (addr),
    .i_wdata   (wdata),
    .o_rdata   (rdata),
    .o_err     (err),
    .o_led     (led),
    .o_num     (num)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic bit is_conf(input logic [31:0] a);
    return a[31:16] == CONF_HI;
  endfunction

  function automatic int ram_key(input logic [31:0] a);
    return int'((a >> 2) % (32'd1 << RAM_AW));
  endfunction

  function automatic bit mapped(input logic [15:0] off);
    return off == 16'hf000 || off == 16'hf010 || off == 16'he000 || off == 16'hfff4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (is_conf(a)) begin
      case (a[15:0])
        16'hf000: return {16'h0, m_led};
        16'hf010: return m_num;
        16'he000: return m_timer;
        16'hfff4: return 32'hffff_ffff;
        default:  return 32'h0;
      endcase
    end
    if (m_ram.exists(ram_key(a))) return m_ram[ram_key(a)];
    return 32'h0;
  endfunction

  // One bus cycle: drive at negedge, advance the model at posedge, return at next negedge.
  task automatic step(input logic ce, input logic we, input logic [3:0] sel,
                      input logic [31:0] a, input logic [31:0] d);
    logic [31:0] next_timer;
    logic [31:0] tmp;
    int k;
    memce = ce; memwrite = we; memsel = sel; addr = a; wdata = d;
    @(posedge clk);
    next_timer = m_timer + 32'd1;
    m_err = ce && is_conf(a) && !mapped(a[15:0]);
    if (ce && !we) m_rdata = model_read(a);
    if (ce && we) begin
      if (is_conf(a)) begin
        case (a[15:0])
          16'hf000: begin tmp = lanes({16'h0, m_led}, d, sel); m_led = tmp[15:0]; end
          16'hf010: m_num = lanes(m_num, d, sel);
          16'he000: next_timer = lanes(next_timer, d, sel);
          default: ;
        endcase
      end else begin
        k = ram_key(a);
        m_ram[k] = lanes(m_ram.exists(k) ? m_ram[k] : 32'h0, d, sel);
      end
    end
    m_timer = next_timer;
    @(negedge clk);
  endtask

  task automatic do_reset();
    memce = 1'b0; memwrite = 1'b0; memsel = 4'h0;
    rst = 1'b1;
    m_led = 16'h0; m_num = 32'h0; m_timer = 32'h0; m_rdata = 32'h0; m_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h0); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (led !== 16'h0) begin failures++; $display("FAIL reset_led got=%h exp=0000", led); end
    checks++; if (num !== 32'h0) begin failures++; $display("FAIL reset_num got=%h exp=00000000", num); end
  endtask

  task automatic test_ram_lanes();
    step(1, 1, 4'hf, 32'h0000_0010, 32'h1122_3344);
    step(1, 1, 4'b0100, 32'h0000_0010, 32'h00AA_0000);
    step(1, 0, 4'h0, 32'h0000_0010, $urandom);
    checks++; if (rdata !== 32'h11AA_3344) begin failures++; $display("FAIL lanes_read got=%h exp=%h", rdata, 32'h11AA_3344); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL lanes_err got=%b exp=0", err); end
    step(1, 1, 4'h0, 32'h0000_0010, 32'hffff_ffff);
    step(1, 0, 4'hf, 32'h0000_0010, 32'h0);
    checks++; if (rdata !== 32'h11AA_3344) begin failures++; $display("FAIL lanes_sel0 got=%h exp=%h", rdata, 32'h11AA_3344); end
  endtask

  task automatic test_back_to_back();
    step(1, 1, 4'hf, 32'h0000_0020, 32'hdead_beef);
    step(1, 0, 4'h0, 32'h0000_0020, 32'h0);
    checks++; if (rdata !== 32'hdead_beef) begin failures++; $display("FAIL b2b_read got=%h exp=%h", rdata, 32'hdead_beef); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 4'h0, 32'h0000_0020, 32'h0);
      checks++; if (rdata !== 32'hdead_beef) begin failures++; $display("FAIL b2b_hold%0d got=%h exp=%h", i, rdata, 32'hdead_beef); end
    end
    step(1, 1, 4'hf, 32'h0000_0024, 32'h0123_4567);
    checks++; if (rdata !== 32'hdead_beef) begin failures++; $display("FAIL b2b_wrhold got=%h exp=%h", rdata, 32'hdead_beef); end
  endtask

  task automatic test_alias();
    step(1, 1, 4'hf, 32'h0000_0100, 32'h5a5a_5a5a);
    step(1, 0, 4'h0, 32'h0000_0100 + (32'd4 << RAM_AW), 32'h0);
    checks++; if (rdata !== 32'h5a5a_5a5a) begin failures++; $display("FAIL alias_read got=%h exp=%h", rdata, 32'h5a5a_5a5a); end
  endtask

  task automatic test_confreg();
    step(1, 1, 4'hf, 32'hbfaf_f000, 32'hffff_1234);
    checks++; if (led !== 16'h1234) begin failures++; $display("FAIL conf_led got=%h exp=1234", led); end
    step(1, 0, 4'h0, 32'hbfaf_f000, 32'h0);
    checks++; if (rdata !== 32'h0000_1234) begin failures++; $display("FAIL conf_led_rd got=%h exp=00001234", rdata); end
    step(1, 1, 4'hf, 32'hbfaf_f010, 32'h0000_0042);
    checks++; if (num !== 32'h42) begin failures++; $display("FAIL conf_num got=%h exp=00000042", num); end
    step(1, 0, 4'h0, 32'hbfaf_fff4, 32'h0);
    checks++; if (rdata !== 32'hffff_ffff) begin failures++; $display("FAIL conf_simu got=%h exp=ffffffff", rdata); end
    step(1, 1, 4'hf, 32'hbfaf_fff4, 32'h0);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL conf_simu_wr_err got=%b exp=0", err); end
    step(1, 1, 4'b0010, 32'hbfaf_f000, 32'h0000_ab00);
    checks++; if (led !== 16'hab34) begin failures++; $display("FAIL conf_led_lane got=%h exp=ab34", led); end
  endtask

  task automatic test_timer();
    do_reset();
    for (int i = 0; i < 9; i++) step(0, 0, 4'h0, 32'h0, 32'h0);
    step(1, 0, 4'h0, 32'hbfaf_e000, 32'h0);
    checks++; if (rdata !== 32'd9) begin failures++; $display("FAIL timer_count got=%0d exp=9", rdata); end
    step(1, 1, 4'hf, 32'hbfaf_e000, 32'hffff_fffe);
    step(1, 0, 4'h0, 32'hbfaf_e000, 32'h0);
    checks++; if (rdata !== 32'hffff_fffe) begin failures++; $display("FAIL timer_wr0 got=%h exp=fffffffe", rdata); end
    step(1, 0, 4'h0, 32'hbfaf_e000, 32'h0);
    checks++; if (rdata !== 32'hffff_ffff) begin failures++; $display("FAIL timer_wr1 got=%h exp=ffffffff", rdata); end
    step(1, 0, 4'h0, 32'hbfaf_e000, 32'h0);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL timer_wrap got=%h exp=00000000", rdata); end
  endtask

  task automatic test_err();
    step(1, 0, 4'h0, 32'hbfaf_0000, 32'h0);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL err_rdata got=%h exp=00000000", rdata); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_pulse got=%b exp=1", err); end
    step(0, 0, 4'h0, 32'h0, 32'h0);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_drop got=%b exp=0", err); end
    step(1, 0, 4'h0, 32'hbfaf_0004, 32'h0);
    step(1, 1, 4'hf, 32'hbfaf_1234, 32'h0);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_b2b got=%b exp=1", err); end
    step(0, 0, 4'h0, 32'h0, 32'h0);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_b2b_drop got=%b exp=0", err); end
  endtask

  task automatic test_async_reset();
    step(1, 1, 4'hf, 32'h0000_0040, 32'hcafe_f00d);
    step(1, 1, 4'hf, 32'hbfaf_f000, 32'h0000_55aa);
    step(1, 1, 4'hf, 32'hbfaf_f010, 32'h0000_0077);
    step(1, 0, 4'h0, 32'h0000_0040, 32'h0);
    step(1, 1, 4'hf, 32'hbfaf_0008, 32'h0);
    #2;
    rst = 1'b1;
    memce = 1'b1; memwrite = 1'b1; memsel = 4'hf; addr = 32'h0000_0040; wdata = 32'h0;
    #1;
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL arst_rdata got=%h exp=00000000", rdata); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL arst_err got=%b exp=0", err); end
    checks++; if (led !== 16'h0) begin failures++; $display("FAIL arst_led got=%h exp=0000", led); end
    checks++; if (num !== 32'h0) begin failures++; $display("FAIL arst_num got=%h exp=00000000", num); end
    @(negedge clk);
    memce = 1'b0; memwrite = 1'b0;
    rst = 1'b0;
    m_led = 16'h0; m_num = 32'h0; m_timer = 32'h0; m_rdata = 32'h0; m_err = 1'b0;
    step(1, 0, 4'h0, 32'h0000_0040, 32'h0);
    checks++; if (rdata !== 32'hcafe_f00d) begin failures++; $display("FAIL arst_ram_kept got=%h exp=cafef00d", rdata); end
  endtask

  task automatic test_random();
    logic [31:0] pool [8];
    logic [15:0] offs [8];
    logic [31:0] a;
    logic [3:0]  sel;
    int          kind;
    do_reset();
    offs = '{16'hf000, 16'hf010, 16'he000, 16'hfff4, 16'hf004, 16'h0000, 16'he004, 16'h1230};
    for (int i = 0; i < 8; i++) begin
      pool[i] = $urandom & 32'h3fff_fffc;
      step(1, 1, 4'hf, pool[i], $urandom);
    end
    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 9));
      sel  = 4'($urandom);
      if (kind < 4) begin
        a = (pool[$urandom_range(0, 7)] & ((32'd4 << RAM_AW) - 1))
            | (($urandom & 32'h0000_ffff) << (RAM_AW + 2));
        step(1, 1'($urandom), sel, a, $urandom);
      end else if (kind < 8) begin
        a = {CONF_HI, offs[$urandom_range(0, 7)]};
        if (a[15:0] == 16'he000) sel = 4'hf;
        step(1, 1'($urandom), sel, a, $urandom);
      end else begin
        step(0, 1'($urandom), sel, $urandom, $urandom);
      end
      checks++; if (rdata !== m_rdata) begin failures++; $display("FAIL rnd%0d_rdata got=%h exp=%h", n, rdata, m_rdata); end
      checks++; if (err !== m_err) begin failures++; $display("FAIL rnd%0d_err got=%b exp=%b", n, err, m_err); end
      checks++; if (led !== m_led) begin failures++; $display("FAIL rnd%0d_led got=%h exp=%h", n, led, m_led); end
      checks++; if (num !== m_num) begin failures++; $display("FAIL rnd%0d_num got=%h exp=%h", n, num, m_num); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_ram_lanes();
    test_back_to_back();
    test_alias();
    test_confreg();
    test_timer();
    test_err();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_sram_resp.md
# data_sram_resp

Responder for the CPU data-memory port: the far side of `memce`/`memwriteM`/`memsel`/`aluoutM`/`writedataM`/`readdataM`. Holds the data SRAM and a small confreg page (LEDs, number display, free-running timer, simulation flag). It decodes each request, performs byte-lane writes, and returns registered read data one cycle later. It sits in the SoC top between the CPU core and board I/O.

## Interface
- `RAM_AW`, default 12: word-address width of the data RAM (depth 2^RAM_AW words).
- `CONF_HI`, default 16'hbfaf: `addr[31:16]` value selecting the confreg page.
- `SIMU`, default 1: value presented by the SIMU_FLAG register (1 → 32'hffffffff, 0 → 0).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `memce` in 1: request valid this cycle.
- `memwrite` in 1: 1 = write, 0 = read; ignored when `memce`=0.
- `memsel` in 4: byte-lane write enables, with bit i covering `wdata[8i+7:8i]`. Ignored on reads.
- `addr` in 32: byte address. Bits [1:0] are ignored.
- `wdata` in 32: write data, already lane-aligned by the CPU.
- `rdata` out 32: read data, valid the cycle after the read was accepted.
- `err` out 1: one-cycle pulse flagging an access to an unmapped confreg offset.
- `led` out 16: LED register, low half.
- `num` out 32: number-display register.

## Operation
- Decode, evaluated only when `memce`=1:
  - CONF if `addr[31:16]==CONF_HI`.
  - Otherwise RAM, indexed by `addr[RAM_AW+1:2]`. Higher bits are ignored, so the RAM aliases across the space.
- RAM write: each lane with `memsel[i]`=1 is updated at the edge. Lanes with `memsel[i]`=0 are untouched. `memsel`=0 means no change.
- RAM read: full 32-bit word. `memsel` is ignored. Read-first: a read of a word never coincides with a write (one request per cycle), and a read the cycle after a write returns the new data.
- Confreg map (offset = `addr[15:0]`):
  - 0xf000 LED: RW. Only bits [15:0] are stored; reads return zero-extended.
  - 0xf010 NUM: RW, 32 bits.
  - 0xe000 TIMER: RW. Increments by 1 every cycle, wrapping 0xffffffff→0. A write loads `wdata`, with the written value taking precedence over the increment in that cycle.
  - 0xfff4 SIMU_FLAG: read-only constant. Writes are ignored with no error.
- Confreg writes honour `memsel` per lane, the same as RAM. Lanes beyond bit 15 of LED are discarded.
- Unmapped confreg offset:
  - Read returns 0.
  - Write has no effect.
  - `err` pulses high in the cycle after acceptance.
- `rdata` holds its last value whenever no read is accepted, including write cycles and `memce`=0 cycles.
- `rst` asserted, including mid-operation:
  - Cleared immediately: `rdata`=0, `err`=0, `led`=0, `num`=0, timer=0.
  - RAM contents are not reset.
  - A request presented in the same cycle as reset is dropped.

## Timing
- Requests are accepted every cycle with no back-pressure and no wait states.
- Read latency is exactly 1: a request accepted at edge N drives `rdata` after edge N, so it is sampled by the CPU at edge N+1 in its M/W boundary.
- Write effects are visible at edge N and readable by a read accepted at edge N+1.
- TIMER read value is the count before that edge's increment. Example: timer=5 at edge N with a read → `rdata`=5, timer becomes 6.
- `err` is high for exactly one cycle per bad access. Back-to-back bad accesses hold it high continuously.
- `led`/`num` outputs change at the write edge.

## Test plan
- RAM byte lanes: write 32'h11223344 to 0x0000_0010 with `memsel`=4'hf, then `memsel`=4'b0100 with `wdata`=32'h00AA0000. The read next cycle → `rdata`=32'h11AA3344.
- Back-to-back: write 32'hdeadbeef to 0x20, then immediately read 0x20 → 32'hdeadbeef one cycle later. Then 3 idle cycles → `rdata` holds 32'hdeadbeef.
- Aliasing: write 32'h5a5a5a5a to 0x0000_0100, then read 0x0000_0100 + (4<<RAM_AW) → 32'h5a5a5a5a.
- Confreg:
  - Write 32'hffff1234 to 0xbfaff000 → `led`=16'h1234. A read of it → 32'h00001234.
  - Write 32'h00000042 to 0xbfaff010 → `num`=32'h42.
  - Read 0xbfaffff4 → 32'hffffffff with SIMU=1.
- Timer:
  - Reset, release, read 0xbfafe000 at the 10th edge after release → value 9.
  - Write 32'hfffffffe, then reads on consecutive cycles → 32'hfffffffe, 32'hffffffff, 0.
- Error/reset:
  - Read 0xbfaf0000 → `rdata`=0 and `err` high for one cycle.
  - Assert `rst` mid-stream after a RAM write → `led`/`num`/`rdata`/`err` go to 0 asynchronously, and the prior RAM data is still readable after release.
